// File: rtl/simplebus_mem_slave.sv
// SimpleBus memory slave: backing store behind a cache's memory-side port.
// Handles single read/write and 4-beat critical-word-first bursts, answering
// LATENCY cycles after the request (or final write-burst beat) is accepted.
// Optional build macro SIMPLEBUS_MEM_STATS_EN adds rd_count/wr_count ports.
module simplebus_mem_slave #(
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned LATENCY = 2,
  parameter int unsigned BEATS   = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        req_ready,
  input  logic        req_valid,
  input  logic [31:0] req_bits_addr,
  input  logic [2:0]  req_bits_size,
  input  logic [3:0]  req_bits_cmd,
  input  logic [7:0]  req_bits_wmask,
  input  logic [63:0] req_bits_wdata,
  input  logic [15:0] req_bits_user,
  input  logic        resp_ready,
  output logic        resp_valid,
  output logic [3:0]  resp_bits_cmd,
  output logic [63:0] resp_bits_rdata,
  output logic [15:0] resp_bits_user
`ifdef SIMPLEBUS_MEM_STATS_EN
  ,
  output logic [31:0] rd_count,
  output logic [31:0] wr_count
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW - 2;

  localparam logic [3:0] CMD_WRITE      = 4'h1;
  localparam logic [3:0] CMD_READ_BURST = 4'h2;
  localparam logic [3:0] CMD_WRITE_BURST= 4'h3;
  localparam logic [3:0] CMD_WRITE_LAST = 4'h7;
  localparam logic [3:0] RSP_READ_BURST = 4'h2;
  localparam logic [3:0] RSP_WRITE      = 4'h5;
  localparam logic [3:0] RSP_READ_LAST  = 4'h6;

  typedef enum logic [1:0] {IDLE, WBURST, WAIT, RESP} state_t;
  typedef enum logic [1:0] {TX_READ, TX_RBURST, TX_WRITE} kind_t;

  state_t          state_q, state_d;
  kind_t           kind_q;
  logic [15:0]     user_q;
  logic [LW-1:0]   line_q;
  logic [1:0]      off_q;
  logic [1:0]      cnt_q;
  logic [15:0]     lat_q;

  logic [63:0]     mem [DEPTH];

  logic            accept;
  logic            last_beat;
  logic            is_write_cmd;
  logic            mem_we;
  logic [1:0]      wr_off;
  logic [LW-1:0]   wr_line;
  logic [1:0]      rd_off;
  logic [AW-1:0]   wr_idx;
  logic [AW-1:0]   rd_idx;
  logic            unused_bits;

  // Size and address bits outside the word index are don't-care.
  assign unused_bits = ^{req_bits_size, req_bits_addr[31:AW+3], req_bits_addr[2:0]};

  assign req_ready = !rst && (state_q == IDLE || state_q == WBURST);
  assign accept    = req_valid && req_ready;
  assign last_beat = (kind_q != TX_RBURST) || (cnt_q == 2'(BEATS - 1));

  assign is_write_cmd = (req_bits_cmd == CMD_WRITE) || (req_bits_cmd == CMD_WRITE_BURST) ||
                        (req_bits_cmd == CMD_WRITE_LAST);
  assign mem_we  = accept && ((state_q == WBURST) || is_write_cmd);
  assign wr_off  = (state_q == IDLE) ? req_bits_addr[4:3] : 2'(off_q + cnt_q);
  assign wr_line = (state_q == IDLE) ? req_bits_addr[AW+2:5] : line_q;
  assign wr_idx  = {wr_line, wr_off};
  assign rd_off  = 2'(off_q + cnt_q);
  assign rd_idx  = {line_q, rd_off};

  // Masked byte-lane writes; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int unsigned b = 0; b < 8; b++) begin
        if (req_bits_wmask[b]) mem[wr_idx][8*b +: 8] <= req_bits_wdata[8*b +: 8];
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state and response outputs.
  always_comb begin
    state_d         = state_q;
    resp_valid      = 1'b0;
    resp_bits_cmd   = '0;
    resp_bits_rdata = '0;
    case (state_q)
      IDLE: begin
        if (accept) state_d = (req_bits_cmd == CMD_WRITE_BURST) ? WBURST : WAIT;
      end
      WBURST: begin
        if (accept && req_bits_cmd == CMD_WRITE_LAST) state_d = WAIT;
      end
      WAIT: begin
        if (lat_q == 16'(LATENCY - 1)) state_d = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (kind_q == TX_WRITE) begin
          resp_bits_cmd = RSP_WRITE;
        end else begin
          resp_bits_cmd   = last_beat ? RSP_READ_LAST : RSP_READ_BURST;
          resp_bits_rdata = mem[rd_idx];
        end
        if (resp_ready && last_beat) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign resp_bits_user = user_q;

  // Transaction context: tag, line, offset, beat and latency counters.
  // cnt_q is shared: write-burst beat index, then response beat index.
  always_ff @(posedge clk) begin
    if (rst) begin
      kind_q <= TX_READ;
      user_q <= '0;
      line_q <= '0;
      off_q  <= '0;
      cnt_q  <= '0;
      lat_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            user_q <= req_bits_user;
            line_q <= req_bits_addr[AW+2:5];
            off_q  <= req_bits_addr[4:3];
            lat_q  <= '0;
            cnt_q  <= (req_bits_cmd == CMD_WRITE_BURST) ? 2'd1 : 2'd0;
            if (is_write_cmd)                        kind_q <= TX_WRITE;
            else if (req_bits_cmd == CMD_READ_BURST) kind_q <= TX_RBURST;
            else                                     kind_q <= TX_READ;
          end
        end
        WBURST: begin
          if (accept) cnt_q <= (req_bits_cmd == CMD_WRITE_LAST) ? 2'd0 : 2'(cnt_q + 2'd1);
        end
        WAIT: lat_q <= 16'(lat_q + 16'd1);
        RESP: begin
          if (resp_ready) cnt_q <= last_beat ? 2'd0 : 2'(cnt_q + 2'd1);
        end
        default: ;
      endcase
    end
  end

`ifdef SIMPLEBUS_MEM_STATS_EN
  // Completed-transaction counters, counted at the final response handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_count <= '0;
      wr_count <= '0;
    end else if (resp_valid && resp_ready && last_beat) begin
      if (kind_q == TX_WRITE) wr_count <= wr_count + 32'd1;
      else                    rd_count <= rd_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_simplebus_mem_slave.sv
// Directed bench for simplebus_mem_slave (LATENCY=2): scoreboard of expected
// response beats, checked at each response handshake.
module tb_simplebus_mem_slave;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_ready;
  logic        req_valid;
  logic [31:0] req_bits_addr;
  logic [2:0]  req_bits_size;
  logic [3:0]  req_bits_cmd;
  logic [7:0]  req_bits_wmask;
  logic [63:0] req_bits_wdata;
  logic [15:0] req_bits_user;
  logic        resp_ready;
  logic        resp_valid;
  logic [3:0]  resp_bits_cmd;
  logic [63:0] resp_bits_rdata;
  logic [15:0] resp_bits_user;
`ifdef SIMPLEBUS_MEM_STATS_EN
  logic [31:0] rd_count;
  logic [31:0] wr_count;
`endif

  simplebus_mem_slave #(.DEPTH(1024), .LATENCY(2), .BEATS(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .req_ready       (req_ready),
    .req_valid       (req_valid),
    .req_bits_addr   (req_bits_addr),
    .req_bits_size   (req_bits_size),
    .req_bits_cmd    (req_bits_cmd),
    .req_bits_wmask  (req_bits_wmask),
    .req_bits_wdata  (req_bits_wdata),
    .req_bits_user   (req_bits_user),
    .resp_ready      (resp_ready),
    .resp_valid      (resp_valid),
    .resp_bits_cmd   (resp_bits_cmd),
    .resp_bits_rdata (resp_bits_rdata),
    .resp_bits_user  (resp_bits_user)
`ifdef SIMPLEBUS_MEM_STATS_EN
    ,
    .rd_count        (rd_count),
    .wr_count        (wr_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  cmd;
    logic [63:0] rdata;
    logic [15:0] user;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   exp_rd = 0;
  int   exp_wr = 0;

  localparam logic [63:0] DA = 64'hA1A1_A1A1_0000_000A;
  localparam logic [63:0] DB = 64'hB2B2_B2B2_0000_000B;
  localparam logic [63:0] DC = 64'hC3C3_C3C3_0000_000C;
  localparam logic [63:0] DD = 64'hD4D4_D4D4_0000_000D;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [3:0] cmd, input logic [63:0] data, input logic [15:0] user);
    sb.push_back('{cmd: cmd, rdata: data, user: user});
  endtask

  // Present one request beat and hold it until accepted (bounded).
  task automatic send(input logic [3:0] cmd, input logic [31:0] addr, input logic [7:0] wm,
                      input logic [63:0] wd, input logic [15:0] user);
    bit done;
    done           = 1'b0;
    req_valid      = 1'b1;
    req_bits_cmd   = cmd;
    req_bits_addr  = addr;
    req_bits_wmask = wm;
    req_bits_wdata = wd;
    req_bits_user  = user;
    req_bits_size  = 3'd3;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (req_ready) begin
        @(posedge clk);
        #1;
        done = 1'b1;
      end
    end
    req_valid = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $error("FAIL req_accept_timeout observed=not_accepted expected=accepted");
    end
  endtask

  // Wait (bounded) until every expected beat has been returned.
  task automatic drain(input string tag);
    int n;
    n = 0;
    @(posedge clk);
    #1;
    while ((sb.size() != 0 || resp_valid) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(tag, 64'(sb.size()), 64'd0);
  endtask

  task automatic wr1(input logic [31:0] addr, input logic [7:0] wm, input logic [63:0] wd,
                     input logic [15:0] user);
    push(4'h5, 64'd0, user);
    exp_wr++;
    send(4'h1, addr, wm, wd, user);
    drain("write_drain");
  endtask

  // Response monitor: compare every handshaked beat with the scoreboard head.
  always @(negedge clk) begin
    if (!rst && resp_valid && resp_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL resp_unexpected observed=cmd %h data %h expected=no response",
               resp_bits_cmd, resp_bits_rdata);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("resp_cmd", 64'(resp_bits_cmd), 64'(e.cmd));
        chk("resp_rdata", resp_bits_rdata, e.rdata);
        chk("resp_user", 64'(resp_bits_user), 64'(e.user));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req_valid = 1'b0; resp_ready = 1'b1;
    req_bits_addr = '0; req_bits_size = '0; req_bits_cmd = '0;
    req_bits_wmask = '0; req_bits_wdata = '0; req_bits_user = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("idle_req_ready", 64'(req_ready), 64'd1);
    chk("idle_resp_valid", 64'(resp_valid), 64'd0);
    chk("idle_resp_cmd", 64'(resp_bits_cmd), 64'd0);
    chk("idle_resp_rdata", resp_bits_rdata, 64'd0);
    chk("idle_resp_user", 64'(resp_bits_user), 64'd0);
`ifdef SIMPLEBUS_MEM_STATS_EN
    chk("rst_rd_count", 64'(rd_count), 64'd0);
    chk("rst_wr_count", 64'(wr_count), 64'd0);
`endif
    @(posedge clk); #1;

    // Single write with latency timing
    push(4'h5, 64'd0, 16'h000A);
    exp_wr++;
    send(4'h1, 32'h100, 8'hFF, 64'h1122334455667788, 16'h000A);
    @(negedge clk);
    chk("lat_valid_c1", 64'(resp_valid), 64'd0);
    chk("wait_req_ready", 64'(req_ready), 64'd0);
    @(negedge clk);
    chk("lat_valid_c2", 64'(resp_valid), 64'd0);
    @(negedge clk);
    chk("lat_valid_c3", 64'(resp_valid), 64'd1);
    drain("write_resp_drain");
    chk("post_resp_req_ready", 64'(req_ready), 64'd1);

    // Single read back
    push(4'h6, 64'h1122334455667788, 16'h000B);
    exp_rd++;
    send(4'h0, 32'h100, 8'h00, 64'd0, 16'h000B);
    drain("read_drain");

    // Partial mask write then read
    wr1(32'h100, 8'h0F, 64'hAAAAAAAABBBBBBBB, 16'h000C);
    push(4'h6, 64'h11223344BBBBBBBB, 16'h000D);
    exp_rd++;
    send(4'h0, 32'h100, 8'h00, 64'd0, 16'h000D);
    drain("partial_read_drain");

    // Preload line 0x200 (last word via writeLast as a single write)
    wr1(32'h200, 8'hFF, 64'd0, 16'h0020);
    wr1(32'h208, 8'hFF, 64'd1, 16'h0021);
    wr1(32'h210, 8'hFF, 64'd2, 16'h0022);
    push(4'h5, 64'd0, 16'h0023);
    exp_wr++;
    send(4'h7, 32'h218, 8'hFF, 64'd3, 16'h0023);
    drain("writelast_drain");

    // Unlisted command code behaves as a single read
    push(4'h6, 64'd1, 16'h0024);
    exp_rd++;
    send(4'h4, 32'h208, 8'h00, 64'd0, 16'h0024);
    drain("cmd4_read_drain");

    // Wrapping readBurst with backpressure after the first beat
    push(4'h2, 64'd2, 16'h0030);
    push(4'h2, 64'd3, 16'h0030);
    push(4'h2, 64'd0, 16'h0030);
    push(4'h6, 64'd1, 16'h0030);
    exp_rd++;
    resp_ready = 1'b0;
    send(4'h2, 32'h210, 8'h00, 64'd0, 16'h0030);
    for (int i = 0; i < 20 && !resp_valid; i++) @(negedge clk);
    chk("burst_valid_seen", 64'(resp_valid), 64'd1);
    @(posedge clk); #1;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_valid", 64'(resp_valid), 64'd1);
      chk("stall_rdata", resp_bits_rdata, 64'd3);
      chk("stall_cmd", 64'(resp_bits_cmd), 64'h2);
    end
    @(posedge clk); #1;
    resp_ready = 1'b1;
    drain("burst_read_drain");

    // Write burst; later beats carry junk addresses which must be ignored
    send(4'h3, 32'h300, 8'hFF, DA, 16'h0060);
    send(4'h3, 32'hFFFF_F0F8, 8'hFF, DB, 16'h0061);
    send(4'h3, 32'h0000_0010, 8'hFF, DC, 16'h0062);
    push(4'h5, 64'd0, 16'h0060);
    exp_wr++;
    send(4'h7, 32'h1234_5678, 8'hFF, DD, 16'h0063);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("wburst_req_ready_low", 64'(req_ready), 64'd0);
    end
    drain("wburst_drain");
    chk("wburst_req_ready_back", 64'(req_ready), 64'd1);

    push(4'h2, DA, 16'h0070);
    push(4'h2, DB, 16'h0070);
    push(4'h2, DC, 16'h0070);
    push(4'h6, DD, 16'h0070);
    exp_rd++;
    send(4'h2, 32'h300, 8'h00, 64'd0, 16'h0070);
    drain("wburst_readback_drain");

`ifdef SIMPLEBUS_MEM_STATS_EN
    chk("pre_rst_rd_count", 64'(rd_count), 64'(exp_rd));
    chk("pre_rst_wr_count", 64'(wr_count), 64'(exp_wr));
`endif

    // Reset during WAIT of a read: response must be dropped
    send(4'h0, 32'h100, 8'h00, 64'd0, 16'h0080);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_req_ready", 64'(req_ready), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("postrst_resp_valid", 64'(resp_valid), 64'd0);
      chk("postrst_req_ready", 64'(req_ready), 64'd1);
    end
`ifdef SIMPLEBUS_MEM_STATS_EN
    chk("postrst_rd_count", 64'(rd_count), 64'd0);
    chk("postrst_wr_count", 64'(wr_count), 64'd0);
`endif
    @(posedge clk); #1;

    push(4'h6, 64'h11223344BBBBBBBB, 16'h0090);
    send(4'h0, 32'h100, 8'h00, 64'd0, 16'h0090);
    drain("postrst_read_drain");
    push(4'h6, DC, 16'h0091);
    send(4'h0, 32'h310, 8'h00, 64'd0, 16'h0091);
    drain("postrst_read2_drain");
`ifdef SIMPLEBUS_MEM_STATS_EN
    chk("final_rd_count", 64'(rd_count), 64'd2);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/simplebus_mem_slave.md
Name: simplebus_mem_slave

Overview:
- Synthesizable SimpleBus memory slave that sits directly downstream of the cache's memory-side SimpleBus port.
- Consumes the cache's refill and writeback requests, and returns responses after a programmable latency.
- Supports single read/write plus 4-beat wrapping read/write bursts.
- Used as the backing store in cache simulation benches.

Parameters:
- DEPTH, 1024: number of 64-bit words; must be a power of two.
- LATENCY, 2: cycles from request acceptance to first response beat; must be ≥1.
- BEATS, 4: burst length in beats (32-byte line); fixed at 4.

Ports:
- clk  input  1  clock
- rst  input  1  reset; synchronous, active-high
- req_ready  output  1  slave can accept a request beat
- req_valid  input  1  request beat valid
- req_bits_addr  input  32  byte address; word index = addr[log2(DEPTH)+2:3], upper bits ignored (wrap modulo DEPTH)
- req_bits_size  input  3  access size; ignored, wmask governs writes
- req_bits_cmd  input  4  0x0 read, 0x1 write, 0x2 readBurst, 0x3 writeBurst, 0x7 writeLast
- req_bits_wmask  input  8  byte-lane write enables
- req_bits_wdata  input  64  write data
- req_bits_user  input  16  tag echoed in the response
- resp_ready  input  1  master can accept a response beat
- resp_valid  output  1  response beat valid
- resp_bits_cmd  output  4  0x6 readLast on final read beat, 0x2 on non-final read-burst beats, 0x5 writeResp
- resp_bits_rdata  output  64  read data; 0 for writeResp
- resp_bits_user  output  16  user tag latched from the first request beat

Behaviour:
- Reset: state IDLE; req_ready=0 during rst, then 1 in IDLE; resp_valid=0; resp_bits_cmd=0, rdata=0, user=0. Memory contents are not cleared.
- Handshake: a beat transfers on valid&ready at posedge. resp_valid, once high, holds with stable bits until resp_ready=1.
- FSM states: IDLE, WBURST, WAIT, RESP.
- IDLE: req_ready=1. On accept, latch user, line base (addr[31:5]), word offset (addr[4:3]), and cmd.
  - cmd 0x1 or 0x7: masked byte write in the same cycle, then WAIT (writeResp).
  - cmd 0x3: write beat 0 at the offset, beat counter=1, then WBURST.
  - cmd 0x2: readBurst; go to WAIT.
  - any other cmd (0x0, 0x4, 0x8, ...): single read; go to WAIT.
- WBURST: req_ready=1; each accepted beat writes word (offset+cnt) mod 4 within the line; addr is ignored on later beats.
  - cmd 0x7 ends the burst and goes to WAIT.
  - cmd 0x3 increments cnt mod 4 and stays in WBURST.
- WAIT: req_ready=0; counter runs LATENCY-1 cycles. resp_valid rises exactly LATENCY cycles after the accepting edge. LATENCY=1 means resp_valid in the next cycle.
- RESP: req_ready=0.
  - Single read: one beat, cmd 0x6, data at the latched index.
  - readBurst: 4 beats at offsets o, o+1, o+2, o+3 mod 4 (critical-word-first wrap); beats 0–2 cmd 0x2, beat 3 cmd 0x6.
  - A beat advances only on resp_ready; resp_ready=0 stalls with data held.
  - Write: one beat, cmd 0x5.
  - Return to IDLE after the final beat handshakes; req_ready=1 in the following cycle.
- Ordering: a read always returns data from all previously completed writes. There is no overlap; at most one transaction is outstanding.
- Reading a never-written word returns X in simulation; the bench must initialise.
- Reset mid-transaction: abort immediately to IDLE and drop the pending response. Writes already performed remain.

Optional Feature:
- Macro: SIMPLEBUS_MEM_STATS_EN.
- When defined: adds output ports rd_count[31:0] and wr_count[31:0], both reset to 0.
  - rd_count increments on each completed read transaction (final read beat handshake).
  - wr_count increments on each writeResp handshake.
  - Counters wrap at 2^32.
- When undefined: ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- Single write then read (LATENCY=2): write addr 0x100, wdata 0x1122334455667788, wmask 0xFF, user 0x0A → writeResp cmd 0x5, user 0x0A, 2 cycles after accept. Read 0x100 → cmd 0x6, rdata 0x1122334455667788.
- Partial mask: write 0x100 wmask 0x0F, wdata 0xAAAAAAAABBBBBBBB, then read 0x100 → 0x11223344BBBBBBBB.
- Wrapping readBurst: preload words 0x200..0x218 with 0,1,2,3; readBurst at addr 0x210 → data 2,3,0,1 with cmds 0x2,0x2,0x2,0x6.
- Response backpressure: hold resp_ready=0 for 5 cycles mid-burst → resp_valid stays 1 with beat data stable, and no beat is lost.
- Write burst: cmds 0x3,0x3,0x3,0x7 at base 0x300 with data A,B,C,D → one writeResp. A readBurst at 0x300 then returns A,B,C,D. req_ready=0 from the accept of beat 3 until the writeResp handshake.
- Reset during WAIT of a read: assert rst for 1 cycle → no response, resp_valid=0, req_ready=1 after rst deasserts; earlier memory contents intact. With SIMPLEBUS_MEM_STATS_EN, counters read 0 after reset.
